// File: rtl/mix_sync_fifo.sv
// Single-clock FIFO with standard or first-word-fall-through read mode and registered flags.
// Define MIX_SYNC_FIFO_STICKY_ERR_EN to make overflow/underflow sticky until err_clr or reset.
module mix_sync_fifo #(
  parameter int DEPTH_WIDTH      = 10,
  parameter int DATA_WIDTH       = 16,
  parameter int ALMOST_FULL_NUM  = 1020,
  parameter int ALMOST_EMPTY_NUM = 4,
  parameter int FWFT             = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [DATA_WIDTH-1:0]  wr_data,
  output logic                   wr_full,
  output logic                   almost_full,
  output logic [DEPTH_WIDTH:0]   water_level,
  input  logic                   rd_en,
  output logic [DATA_WIDTH-1:0]  rd_data,
  output logic                   rd_valid,
  output logic                   rd_empty,
  output logic                   almost_empty,
  input  logic                   err_clr,
  output logic                   overflow,
  output logic                   underflow
);
  localparam int D = 1 << DEPTH_WIDTH;
  localparam logic [DEPTH_WIDTH:0] FULL_LVL = (DEPTH_WIDTH+1)'(D);
  localparam logic [DEPTH_WIDTH:0] AF_LVL   = (DEPTH_WIDTH+1)'(ALMOST_FULL_NUM);
  localparam logic [DEPTH_WIDTH:0] AE_LVL   = (DEPTH_WIDTH+1)'(ALMOST_EMPTY_NUM);

  logic [DATA_WIDTH-1:0]  mem [D];
  logic [DEPTH_WIDTH:0]   wr_ptr, rd_ptr, level, level_nxt;
  logic                   wr_acc, rd_acc, ram_has, stage_load, stage_full_nxt;
  logic                   ovf_drop, udf_drop;

  // Handshake: a write is taken when wr_en=1 and wr_full=0, a read/pop when
  // rd_en=1 and rd_empty=0; any other request is dropped and flagged.
  assign wr_acc   = wr_en & ~wr_full;
  assign rd_acc   = rd_en & ~rd_empty;
  assign ovf_drop = wr_en & wr_full;
  assign udf_drop = rd_en & rd_empty;
  assign ram_has  = (wr_ptr != rd_ptr);

  // FWFT refills the output stage from RAM whenever it is empty or being popped.
  assign stage_load     = (FWFT != 0) ? (ram_has & (rd_empty | rd_acc)) : rd_acc;
  assign stage_full_nxt = stage_load | (~rd_empty & ~rd_acc);

  always_comb begin
    level_nxt = level;
    if (wr_acc && !rd_acc)
      level_nxt = level + 1'b1;
    else if (rd_acc && !wr_acc)
      level_nxt = level - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst_n && wr_acc)
      mem[wr_ptr[DEPTH_WIDTH-1:0]] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      wr_full      <= 1'b0;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      rd_empty     <= 1'b1;
      rd_valid     <= 1'b0;
      rd_data      <= '0;
    end else begin
      if (wr_acc)
        wr_ptr <= wr_ptr + 1'b1;
      if (stage_load) begin
        rd_data <= mem[rd_ptr[DEPTH_WIDTH-1:0]];
        rd_ptr  <= rd_ptr + 1'b1;
      end
      level        <= level_nxt;
      wr_full      <= (level_nxt == FULL_LVL);
      almost_full  <= (level_nxt >= AF_LVL);
      almost_empty <= (level_nxt <= AE_LVL);
      if (FWFT != 0) begin
        rd_empty <= ~stage_full_nxt;
        rd_valid <= stage_full_nxt;
      end else begin
        rd_empty <= (level_nxt == '0);
        rd_valid <= rd_acc;
      end
    end
  end

  assign water_level = level;

`ifdef MIX_SYNC_FIFO_STICKY_ERR_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= ovf_drop | (overflow & ~err_clr);
      underflow <= udf_drop | (underflow & ~err_clr);
    end
  end
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= ovf_drop;
      underflow <= udf_drop;
    end
  end
`endif

endmodule

// File: tb/tb_mix_sync_fifo.sv
// Bench for mix_sync_fifo: a standard-mode and an FWFT instance share one stimulus stream
// and are checked every cycle against a queue model plus hand-computed literal points.
module tb_mix_sync_fifo;
  localparam int DW = 4;
  localparam int W  = 16;
  localparam int D  = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [W-1:0]  wr_data = '0;
  logic          rd_en = 1'b0;
  logic          err_clr = 1'b0;

  logic          s_full, s_afull, s_rvalid, s_empty, s_aempty, s_ovf, s_udf;
  logic [DW:0]   s_level;
  logic [W-1:0]  s_rdata;
  logic          f_full, f_afull, f_rvalid, f_empty, f_aempty, f_ovf, f_udf;
  logic [DW:0]   f_level;
  logic [W-1:0]  f_rdata;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  mix_sync_fifo #(.DEPTH_WIDTH(DW), .DATA_WIDTH(W), .ALMOST_FULL_NUM(14),
                  .ALMOST_EMPTY_NUM(2), .FWFT(0)) u_std (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .wr_full(s_full),
    .almost_full(s_afull), .water_level(s_level), .rd_en(rd_en), .rd_data(s_rdata),
    .rd_valid(s_rvalid), .rd_empty(s_empty), .almost_empty(s_aempty),
    .err_clr(err_clr), .overflow(s_ovf), .underflow(s_udf));

  mix_sync_fifo #(.DEPTH_WIDTH(DW), .DATA_WIDTH(W), .ALMOST_FULL_NUM(14),
                  .ALMOST_EMPTY_NUM(2), .FWFT(1)) u_fwft (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .wr_full(f_full),
    .almost_full(f_afull), .water_level(f_level), .rd_en(rd_en), .rd_data(f_rdata),
    .rd_valid(f_rvalid), .rd_empty(f_empty), .almost_empty(f_aempty),
    .err_clr(err_clr), .overflow(f_ovf), .underflow(f_udf));

  always #5 clk = ~clk;

  // Reference state: standard FIFO is a plain queue; FWFT is a queue behind a one-word stage.
  logic [W-1:0] exp_q[$];
  logic [W-1:0] m_s_rdata;
  bit           m_s_rvalid, m_s_ovf, m_s_udf;
  logic [W-1:0] f_ram_q[$];
  logic [W-1:0] m_f_data;
  int           m_f_sv;
  bit           m_f_ovf, m_f_udf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit s_wok, s_rok, f_wok, f_pop;
    int f_lvl;
    if (!rst_n) begin
      exp_q.delete();
      m_s_rdata = '0; m_s_rvalid = 0; m_s_ovf = 0; m_s_udf = 0;
      f_ram_q.delete();
      m_f_data = '0; m_f_sv = 0; m_f_ovf = 0; m_f_udf = 0;
    end else begin
      s_wok = wr_en && (exp_q.size() < D);
      s_rok = rd_en && (exp_q.size() > 0);
`ifdef MIX_SYNC_FIFO_STICKY_ERR_EN
      m_s_ovf = (wr_en && !s_wok) || (m_s_ovf && !err_clr);
      m_s_udf = (rd_en && !s_rok) || (m_s_udf && !err_clr);
`else
      m_s_ovf = wr_en && !s_wok;
      m_s_udf = rd_en && !s_rok;
`endif
      m_s_rvalid = s_rok;
      if (s_rok) m_s_rdata = exp_q.pop_front();
      if (s_wok) exp_q.push_back(wr_data);

      f_lvl = f_ram_q.size() + m_f_sv;
      f_wok = wr_en && (f_lvl < D);
      f_pop = rd_en && (m_f_sv != 0);
`ifdef MIX_SYNC_FIFO_STICKY_ERR_EN
      m_f_ovf = (wr_en && !f_wok) || (m_f_ovf && !err_clr);
      m_f_udf = (rd_en && m_f_sv == 0) || (m_f_udf && !err_clr);
`else
      m_f_ovf = wr_en && !f_wok;
      m_f_udf = rd_en && m_f_sv == 0;
`endif
      if (f_ram_q.size() > 0 && (m_f_sv == 0 || f_pop)) begin
        m_f_data = f_ram_q.pop_front();
        m_f_sv = 1;
      end else if (f_pop) begin
        m_f_sv = 0;
      end
      if (f_wok) f_ram_q.push_back(wr_data);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      int sl, fl;
      sl = exp_q.size();
      fl = f_ram_q.size() + m_f_sv;
      chk("std_level",  32'(s_level),  32'(sl));
      chk("std_full",   32'(s_full),   32'(sl == D));
      chk("std_afull",  32'(s_afull),  32'(sl >= 14));
      chk("std_empty",  32'(s_empty),  32'(sl == 0));
      chk("std_aempty", 32'(s_aempty), 32'(sl <= 2));
      chk("std_rvalid", 32'(s_rvalid), 32'(m_s_rvalid));
      chk("std_rdata",  32'(s_rdata),  32'(m_s_rdata));
      chk("std_ovf",    32'(s_ovf),    32'(m_s_ovf));
      chk("std_udf",    32'(s_udf),    32'(m_s_udf));
      chk("fw_level",   32'(f_level),  32'(fl));
      chk("fw_full",    32'(f_full),   32'(fl == D));
      chk("fw_afull",   32'(f_afull),  32'(fl >= 14));
      chk("fw_empty",   32'(f_empty),  32'(m_f_sv == 0));
      chk("fw_aempty",  32'(f_aempty), 32'(fl <= 2));
      chk("fw_rvalid",  32'(f_rvalid), 32'(m_f_sv != 0));
      chk("fw_ovf",     32'(f_ovf),    32'(m_f_ovf));
      chk("fw_udf",     32'(f_udf),    32'(m_f_udf));
      if (m_f_sv != 0) chk("fw_rdata", 32'(f_rdata), 32'(m_f_data));
    end
  end

  task automatic chk_reset_values(input string tag);
    chk({tag, "_s_level"}, 32'(s_level), 0);
    chk({tag, "_s_empty"}, 32'(s_empty), 1);
    chk({tag, "_s_full"},  32'(s_full),  0);
    chk({tag, "_s_aempty"}, 32'(s_aempty), 1);
    chk({tag, "_s_afull"}, 32'(s_afull), 0);
    chk({tag, "_s_rdata"}, 32'(s_rdata), 0);
    chk({tag, "_s_rvalid"}, 32'(s_rvalid), 0);
    chk({tag, "_s_ovf"},   32'(s_ovf),   0);
    chk({tag, "_s_udf"},   32'(s_udf),   0);
    chk({tag, "_f_level"}, 32'(f_level), 0);
    chk({tag, "_f_empty"}, 32'(f_empty), 1);
    chk({tag, "_f_rdata"}, 32'(f_rdata), 0);
    chk({tag, "_f_rvalid"}, 32'(f_rvalid), 0);
  endtask

  function automatic logic [W-1:0] wrap_seq(input int j);
    return (j < 8) ? W'(16'h0100 + j) : W'(16'h0200 + j - 8);
  endfunction

  initial begin
    // reset with requests asserted: they must be ignored
    rst_n = 1'b0; wr_en = 1'b1; rd_en = 1'b1; wr_data = 16'hDEAD;
    cyc();
    chk_en = 1'b1;
    cyc(); cyc();
    wr_en = 1'b0; rd_en = 1'b0;
    chk_reset_values("rst0");
    rst_n = 1'b1;

    // fill 16 words, then one write too many
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_data = W'(i);
      cyc();
      chk("fill_afull", 32'(s_afull), 32'(i + 1 >= 14));
      chk("fill_full",  32'(s_full),  32'(i == 15));
    end
    chk("fill_level", 32'(s_level), 16);
    wr_data = 16'h0010;
    cyc();
    wr_en = 1'b0;
    chk("ovf_set_s", 32'(s_ovf), 1);
    chk("ovf_set_f", 32'(f_ovf), 1);
    chk("ovf_level", 32'(s_level), 16);
    for (int i = 0; i < 20; i++) begin
      cyc();
`ifdef MIX_SYNC_FIFO_STICKY_ERR_EN
      chk("ovf_hold", 32'(s_ovf), 1);
`else
      chk("ovf_pulse", 32'(s_ovf), 0);
`endif
    end
    err_clr = 1'b1; cyc(); err_clr = 1'b0;
    chk("ovf_clr", 32'(s_ovf), 0);

    // drain all 16 words in standard order, then one read too many
    for (int i = 0; i < 16; i++) begin
      rd_en = 1'b1;
      cyc();
      chk("drain_data",  32'(s_rdata), 32'(i));
      chk("drain_valid", 32'(s_rvalid), 1);
    end
    chk("drain_empty", 32'(s_empty), 1);
    cyc();
    rd_en = 1'b0;
    chk("udf_set_s", 32'(s_udf), 1);
    chk("udf_set_f", 32'(f_udf), 1);
    chk("udf_hold_data", 32'(s_rdata), 16'h000F);
    chk("udf_rvalid", 32'(s_rvalid), 0);
    err_clr = 1'b1; cyc(); err_clr = 1'b0;

    // FWFT visibility latency for a single word
    wr_en = 1'b1; wr_data = 16'hABCD;
    cyc();
    wr_en = 1'b0;
    chk("fw_n_empty", 32'(f_empty), 1);
    chk("fw_n_level", 32'(f_level), 1);
    cyc();
    chk("fw_n1_empty", 32'(f_empty), 0);
    chk("fw_n1_data",  32'(f_rdata), 16'hABCD);
    rd_en = 1'b1;
    cyc();
    rd_en = 1'b0;
    chk("fw_pop_empty", 32'(f_empty), 1);
    chk("fw_pop_level", 32'(f_level), 0);
    chk("std_abcd", 32'(s_rdata), 16'hABCD);

    // level 8, then 40 cycles of simultaneous write and read across the pointer wrap
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_data = wrap_seq(i);
      cyc();
    end
    wr_en = 1'b0;
    cyc(); cyc();
    for (int k = 0; k < 40; k++) begin
      wr_en = 1'b1; rd_en = 1'b1; wr_data = wrap_seq(k + 8);
      cyc();
      chk("wrap_s_level", 32'(s_level), 8);
      chk("wrap_f_level", 32'(f_level), 8);
      chk("wrap_s_data",  32'(s_rdata), 32'(wrap_seq(k)));
      chk("wrap_f_data",  32'(f_rdata), 32'(wrap_seq(k + 1)));
    end
    wr_en = 1'b0; rd_en = 1'b0;

    // raise to level 10, reset mid-operation, then check for stale data
    wr_en = 1'b1; wr_data = 16'h0300; cyc();
    wr_data = 16'h0301; cyc();
    chk("pre_rst_level", 32'(s_level), 10);
    rst_n = 1'b0; rd_en = 1'b1;
    cyc();
    rst_n = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
    chk_reset_values("rst1");
    wr_en = 1'b1; wr_data = 16'h1234;
    cyc();
    wr_en = 1'b0;
    cyc();
    chk("post_rst_f_data", 32'(f_rdata), 16'h1234);
    rd_en = 1'b1;
    cyc();
    rd_en = 1'b0;
    chk("post_rst_s_data",  32'(s_rdata), 16'h1234);
    chk("post_rst_s_valid", 32'(s_rvalid), 1);
    chk("post_rst_level",   32'(s_level), 0);
    cyc(); cyc();

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
